// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer with byte-lane steering,
// load sign extension and an ack timeout that raises BusError.
module mem_access_unit #(
   parameter int MAX_WAIT = 15
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic        MemByte,
   input  logic        MemHalf,
   input  logic [31:0] Addr,
   input  logic [31:0] WriteData,
   input  logic        MemAck,
   input  logic [31:0] MemRData,
   output logic        MemReq,
   output logic        MemWe,
   output logic [31:0] MemAddr,
   output logic [3:0]  MemBe,
   output logic [31:0] MemWData,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        Misalign,
   output logic        BusError
);
   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;
   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        req_q, req_d, we_q, we_d, mis_q, mis_d, berr_q, berr_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic [3:0]  be_q, be_d;
   logic [1:0]  sz_q, sz_d, off_q, off_d;
   logic        is_byte, is_half, access, aligned;
   logic [3:0]  be;
   logic [31:0] wdata, ld;
   logic [15:0] lane;
   // Both size bits high decodes as a byte access.
   assign is_byte = MemByte;
   assign is_half = MemHalf & ~MemByte;
   assign access  = MemRead | MemWrite;
   assign aligned = is_byte | (is_half ? ~Addr[0] : Addr[1:0] == 2'b00);
   assign be      = is_byte ? 4'b0001 << Addr[1:0] : is_half ? (Addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   assign wdata   = is_byte ? {4{WriteData[7:0]}} : is_half ? {2{WriteData[15:0]}} : WriteData;
   // sz: 2'b10 byte, 2'b01 half, 2'b00 word; off is the byte offset of the access.
   assign lane    = 16'(MemRData >> {off_q, 3'b000});
   assign ld      = sz_q[1] ? {{24{lane[7]}}, lane[7:0]} : sz_q[0] ? {{16{lane[15]}}, lane} : MemRData;
   assign Stall    = state_q == WAIT || (state_q == IDLE && access && aligned);
   assign MemReq   = req_q;
   assign MemWe    = we_q;
   assign MemAddr  = addr_q;
   assign MemBe    = be_q;
   assign MemWData = wdata_q;
   assign ReadData = rdata_q;
   assign Misalign = mis_q;
   assign BusError = berr_q;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      sz_d    = sz_q;
      off_d   = off_q;
      mis_d   = 1'b0;
      berr_d  = 1'b0;
      case (state_q)
         IDLE: if (access) begin
            if (!aligned) begin
               mis_d   = 1'b1;
               rdata_d = '0;
            end else begin
               state_d = WAIT;
               cnt_d   = '0;
               req_d   = 1'b1;
               we_d    = MemWrite;
               addr_d  = {Addr[31:2], 2'b00};
               be_d    = be;
               wdata_d = wdata;
               sz_d    = {is_byte, is_half};
               off_d   = Addr[1:0];
               rdata_d = (MemRead && MemWrite) ? '0 : rdata_q;
            end
         end
         WAIT: if (MemAck) begin
            state_d = DONE;
            req_d   = 1'b0;
            we_d    = 1'b0;
            rdata_d = we_q ? rdata_q : ld;
         end else if (cnt_q == 8'(MAX_WAIT - 1)) begin
            state_d = DONE;
            req_d   = 1'b0;
            we_d    = 1'b0;
            rdata_d = '0;
            berr_d  = 1'b1;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         sz_q    <= '0;
         off_q   <= '0;
         mis_q   <= 1'b0;
         berr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         sz_q    <= sz_d;
         off_q   <= off_d;
         mis_q   <= mis_d;
         berr_q  <= berr_d;
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed load/store vectors with hand-computed
// expectations, run against a MAX_WAIT=4 instance.
module tb_mem_access_unit;
   logic        Clk = 1'b0, Reset = 1'b1;
   logic        MemRead = 1'b0, MemWrite = 1'b0, MemByte = 1'b0, MemHalf = 1'b0;
   logic [31:0] Addr = '0, WriteData = '0, MemRData = '0;
   logic        MemAck = 1'b0;
   logic        MemReq, MemWe, Stall, Misalign, BusError;
   logic [31:0] MemAddr, MemWData, ReadData;
   logic [3:0]  MemBe;
   int          n_tests = 0, n_fail = 0, req_cycles = 0;
   logic        berr_seen;

   mem_access_unit #(.MAX_WAIT(4)) dut (
      .Clk(Clk), .Reset(Reset), .MemRead(MemRead), .MemWrite(MemWrite),
      .MemByte(MemByte), .MemHalf(MemHalf), .Addr(Addr), .WriteData(WriteData),
      .MemAck(MemAck), .MemRData(MemRData), .MemReq(MemReq), .MemWe(MemWe),
      .MemAddr(MemAddr), .MemBe(MemBe), .MemWData(MemWData), .ReadData(ReadData),
      .Stall(Stall), .Misalign(Misalign), .BusError(BusError)
   );

   always #5 Clk = ~Clk;
   always @(negedge Clk) if (MemReq) req_cycles++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive(input logic rd, input logic wr, input logic b, input logic h,
                        input logic [31:0] a, input logic [31:0] wd);
      MemRead = rd; MemWrite = wr; MemByte = b; MemHalf = h; Addr = a; WriteData = wd;
      #1;
   endtask

   task automatic clr();
      drive(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      #3;
      chk("rst_req", MemReq, 0);
      chk("rst_be", MemBe, 0);
      chk("rst_rdata", ReadData, 0);
      chk("rst_stall", Stall, 0);
      chk("rst_err", {Misalign, BusError}, 0);
      tick();
      Reset = 1'b0;

      // lb 0x103, ack on the 2nd WAIT cycle
      drive(1, 0, 1, 0, 32'h103, 0);
      chk("lb_stall0", Stall, 1);
      tick();
      chk("lb_req", MemReq, 1);
      chk("lb_addr", MemAddr, 32'h100);
      chk("lb_be", MemBe, 4'b1000);
      chk("lb_we", MemWe, 0);
      chk("lb_stall1", Stall, 1);
      tick();
      chk("lb_req2", MemReq, 1);
      MemAck = 1'b1; MemRData = 32'h80AABBCC;
      #1;
      chk("lb_stall2", Stall, 1);
      tick();
      MemAck = 1'b0;
      chk("lb_rdata", ReadData, 32'hFFFFFF80);
      chk("lb_done_req", MemReq, 0);
      chk("lb_stall3", Stall, 0);
      clr();
      tick();

      // sh 0x202, immediate ack
      drive(0, 1, 0, 1, 32'h202, 32'h1234ABCD);
      tick();
      chk("sh_addr", MemAddr, 32'h200);
      chk("sh_be", MemBe, 4'b1100);
      chk("sh_wdata", MemWData, 32'hABCDABCD);
      chk("sh_we", MemWe, 1);
      chk("sh_req", MemReq, 1);
      MemAck = 1'b1;
      tick();
      MemAck = 1'b0;
      chk("sh_done_req", {MemReq, MemWe}, 0);
      chk("sh_rdata_kept", ReadData, 32'hFFFFFF80);
      clr();
      tick();

      // misaligned lw 0x006
      req_cycles = 0;
      drive(1, 0, 0, 0, 32'h006, 0);
      chk("mis_stall", Stall, 0);
      tick();
      chk("mis_pulse", Misalign, 1);
      chk("mis_rdata", ReadData, 0);
      clr();
      tick();
      chk("mis_pulse_end", Misalign, 0);
      chk("mis_noreq", req_cycles, 0);

      // back-to-back lw then sw, access left visible during DONE
      req_cycles = 0;
      drive(1, 0, 0, 0, 32'h20, 0);
      tick();
      MemAck = 1'b1; MemRData = 32'h11223344;
      tick();
      MemAck = 1'b0;
      chk("lw_rdata", ReadData, 32'h11223344);
      chk("lw_done_stall", Stall, 0);
      tick();
      chk("lw_no_restart", MemReq, 0);
      drive(0, 1, 0, 0, 32'h24, 32'hCAFEF00D);
      tick();
      chk("sw_req", MemReq, 1);
      chk("sw_wdata", MemWData, 32'hCAFEF00D);
      chk("sw_be", MemBe, 4'b1111);
      chk("sw_addr", MemAddr, 32'h24);
      MemAck = 1'b1;
      tick();
      MemAck = 1'b0;
      clr();
      tick();
      chk("b2b_req_cycles", req_cycles, 2);

      // lw with no ack: timeout after MAX_WAIT=4 request cycles
      req_cycles = 0;
      berr_seen = 1'b0;
      drive(1, 0, 0, 0, 32'h40, 0);
      for (int i = 0; i < 10 && !berr_seen; i++) begin
         tick();
         if (BusError) berr_seen = 1'b1;
      end
      chk("to_berr", berr_seen, 1);
      chk("to_rdata", ReadData, 0);
      chk("to_req_cycles", req_cycles, 4);
      clr();
      tick();
      chk("to_berr_end", BusError, 0);
      chk("to_idle", {MemReq, Stall}, 0);

      // lh 0x10 with Reset in the 2nd WAIT cycle, then a late ack
      drive(1, 0, 0, 1, 32'h10, 0);
      tick();
      tick();
      chk("rw_req_before", MemReq, 1);
      Reset = 1'b1;
      #1;
      chk("rw_req_drop", MemReq, 0);
      clr();
      tick();
      Reset = 1'b0;
      MemAck = 1'b1; MemRData = 32'hFFFF8000;
      tick();
      MemAck = 1'b0;
      chk("rw_late_ack_req", MemReq, 0);
      chk("rw_rdata", ReadData, 0);
      chk("rw_no_err", {Misalign, BusError}, 0);

      // first access after reset: lb 0x001
      drive(1, 0, 1, 0, 32'h001, 0);
      tick();
      chk("pr_be", MemBe, 4'b0010);
      MemAck = 1'b1; MemRData = 32'h00007F00;
      tick();
      MemAck = 1'b0;
      chk("pr_rdata", ReadData, 32'h0000007F);
      clr();
      tick();

      // read+write together with both size bits: byte write only, ReadData cleared
      drive(1, 1, 1, 1, 32'h003, 32'h000000A5);
      tick();
      chk("rw_we", MemWe, 1);
      chk("rw_be", MemBe, 4'b1000);
      chk("rw_wdata", MemWData, 32'hA5A5A5A5);
      MemAck = 1'b1;
      tick();
      MemAck = 1'b0;
      chk("rw_rdata_zero", ReadData, 0);
      clr();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
